// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared op encodings, FSM states and helpers for muldiv_ctrl
package muldiv_ctrl_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Magnitude of a 32-bit operand; only negative values of signed ops are negated.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - EX-stage mul/div request and result bundle
interface muldiv_ctrl_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        advance;
    logic        stall;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start, op, src_a, src_b, flush, advance,
        input  stall, done, hi_out, lo_out
    );

    modport slave (
        input  start, op, src_a, src_b, flush, advance,
        output stall, done, hi_out, lo_out
    );
endinterface

// File: rtl/div_radix2_step.sv
// rtl/div_radix2_step.sv - one combinational restoring-division iteration
module div_radix2_step (
    input  logic [31:0] i_rem,
    input  logic [31:0] i_dvd,
    input  logic [31:0] i_dvs,
    output logic [31:0] o_rem,
    output logic [31:0] o_dvd
);
    logic [32:0] w_shift;
    logic        w_q_bit;

    // Bring the next dividend bit into the partial remainder; subtract only if it fits.
    // The quotient bit is shifted into the freed LSB of the dividend register.
    always_comb begin
        w_shift = {i_rem, i_dvd[31]};
        w_q_bit = (w_shift >= {1'b0, i_dvs});
        o_rem   = w_q_bit ? 32'(w_shift - {1'b0, i_dvs}) : w_shift[31:0];
        o_dvd   = {i_dvd[30:0], w_q_bit};
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - EX-stage mul/div sequencer with stall/done handshake (option: DIV_ZERO_FAST_EN)
import muldiv_ctrl_pkg::*;

module muldiv_ctrl #(
    parameter int MUL_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    muldiv_ctrl_if.slave   bus
);
    state_t      r_state;
    state_t      w_next;

    logic        r_sign_a;
    logic        r_sign_b;
    logic [31:0] r_a_raw;
    logic [63:0] r_prod;
    logic [31:0] r_rem;
    logic [31:0] r_dvd;
    logic [31:0] r_dvs;
    logic [3:0]  r_mul_cnt;
    logic [4:0]  r_div_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_op_signed;
    logic        w_op_div;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [63:0] w_prod;
    logic [63:0] w_mul_res;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_dvd_nxt;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic        w_stall;
    logic        w_done;
`ifdef DIV_ZERO_FAST_EN
    logic        w_div_zero_in;
`endif

    // Operand decode and magnitude/product formation for the accept cycle.
    always_comb begin
        w_op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        w_op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        w_accept    = (r_state == ST_IDLE) && bus.start && !bus.flush;
        w_mag_a     = abs32(bus.src_a, w_op_signed);
        w_mag_b     = abs32(bus.src_b, w_op_signed);
        w_prod      = {32'd0, w_mag_a} * {32'd0, w_mag_b};
`ifdef DIV_ZERO_FAST_EN
        w_div_zero_in = w_op_div && (bus.src_b == 32'd0);
`endif
    end

    div_radix2_step u_step (
        .i_rem (r_rem),
        .i_dvd (r_dvd),
        .i_dvs (r_dvs),
        .o_rem (w_rem_nxt),
        .o_dvd (w_dvd_nxt)
    );

    // Sign fixups; unsigned ops latch zero signs so these pass straight through.
    always_comb begin
        w_mul_res = (r_sign_a ^ r_sign_b) ? (~r_prod + 64'd1) : r_prod;
        w_quo_fix = (r_sign_a ^ r_sign_b) ? (~w_dvd_nxt + 32'd1) : w_dvd_nxt;
        w_rem_fix = r_sign_a ? (~w_rem_nxt + 32'd1) : w_rem_nxt;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; flush aborts from any state, DONE ignores start.
    always_comb begin
        w_next = r_state;
        if (bus.flush) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (!w_op_div) w_next = ST_MUL;
`ifdef DIV_ZERO_FAST_EN
                        else if (w_div_zero_in) w_next = ST_DONE;
`endif
                        else w_next = ST_DIV;
                    end
                end
                ST_MUL:  if (r_mul_cnt == 4'd0) w_next = ST_DONE;
                ST_DIV:  if (r_div_cnt == 5'd0) w_next = ST_DONE;
                ST_DONE: if (bus.advance) w_next = ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Hazard-unit handshake: stall while busy or holding a result, dropped on flush.
    always_comb begin
        w_stall = 1'b0;
        w_done  = 1'b0;
        if (!rst && !bus.flush) begin
            w_stall = (r_state == ST_IDLE) ? bus.start : 1'b1;
            w_done  = (r_state == ST_DONE);
        end
    end

    // Datapath: operand latch on accept, multiply hold countdown, one divide step per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_a_raw   <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_mul_cnt <= '0;
            r_div_cnt <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sign_a  <= w_op_signed & bus.src_a[31];
                        r_sign_b  <= w_op_signed & bus.src_b[31];
                        r_a_raw   <= bus.src_a;
                        r_prod    <= w_prod;
                        r_rem     <= '0;
                        r_dvd     <= w_mag_a;
                        r_dvs     <= w_mag_b;
                        r_mul_cnt <= 4'(MUL_CYCLES - 1);
                        r_div_cnt <= 5'(DIV_ITERS - 1);
`ifdef DIV_ZERO_FAST_EN
                        if (w_div_zero_in) begin
                            r_hi <= bus.src_a;
                            r_lo <= 32'hFFFF_FFFF;
                        end
`endif
                    end
                end
                ST_MUL: begin
                    if (!bus.flush) begin
                        if (r_mul_cnt == 4'd0) {r_hi, r_lo} <= w_mul_res;
                        else                   r_mul_cnt <= r_mul_cnt - 4'd1;
                    end
                end
                ST_DIV: begin
                    if (!bus.flush) begin
                        r_rem <= w_rem_nxt;
                        r_dvd <= w_dvd_nxt;
                        if (r_div_cnt == 5'd0) begin
                            // Zero divisor yields the fixed architectural value, no sign fixup.
                            if (r_dvs == 32'd0) begin
                                r_hi <= r_a_raw;
                                r_lo <= 32'hFFFF_FFFF;
                            end else begin
                                r_hi <= w_rem_fix;
                                r_lo <= w_quo_fix;
                            end
                        end else begin
                            r_div_cnt <= r_div_cnt - 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stall  = w_stall;
    assign bus.done   = w_done;
    assign bus.hi_out = r_hi;
    assign bus.lo_out = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;
    localparam int MC = 4;
`ifdef DIV_ZERO_FAST_EN
    localparam int DZ_CYC = 1;
`else
    localparam int DZ_CYC = 33;
`endif

    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;

    muldiv_ctrl_if bus ();

    muldiv_ctrl #(.MUL_CYCLES(MC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start an op at a negedge (cycle 0) and keep start high until done or timeout.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int dcyc, output int stall_bad);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
        dcyc = -1; stall_bad = 0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (bus.stall !== 1'b1) stall_bad++;
            if (bus.done === 1'b1) begin
                dcyc = c;
                break;
            end
        end
    endtask

    // Retire the op in DONE; returns in the following (IDLE) cycle.
    task automatic release_op;
        @(negedge clk); bus.advance = 1'b1; bus.start = 1'b0;
        @(negedge clk); bus.advance = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd3; bus.src_b = 32'd4;
        bus.flush = 1'b0; bus.advance = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_run++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
        n_run++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_run++; if (bus.hi_out !== 32'd0) begin n_fail++; $display("FAIL reset_hi got=%h exp=0", bus.hi_out); end
        n_run++; if (bus.lo_out !== 32'd0) begin n_fail++; $display("FAIL reset_lo got=%h exp=0", bus.lo_out); end
        bus.start = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        n_run++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL idle_stall got=%b exp=0", bus.stall); end
    endtask

    task automatic test_mult_signed;
        int dc, sb;
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, dc, sb);
        n_run++; if (dc !== MC + 1) begin n_fail++; $display("FAIL mult_latency got=%0d exp=%0d", dc, MC + 1); end
        n_run++; if (sb !== 0) begin n_fail++; $display("FAIL mult_stall got=%0d low cycles exp=0", sb); end
        n_run++; if (bus.hi_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got=%h exp=ffffffff", bus.hi_out); end
        n_run++; if (bus.lo_out !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo got=%h exp=fffffff1", bus.lo_out); end
        release_op();
        n_run++; if ({bus.done, bus.stall} !== 2'b00) begin n_fail++; $display("FAIL mult_release got=%b exp=00", {bus.done, bus.stall}); end
    endtask

    task automatic test_divu;
        int dc, sb;
        run_op(2'b11, 32'd100, 32'd7, dc, sb);
        n_run++; if (dc !== 33) begin n_fail++; $display("FAIL divu_latency got=%0d exp=33", dc); end
        n_run++; if (sb !== 0) begin n_fail++; $display("FAIL divu_stall got=%0d low cycles exp=0", sb); end
        n_run++; if (bus.lo_out !== 32'd14) begin n_fail++; $display("FAIL divu_lo got=%h exp=0000000e", bus.lo_out); end
        n_run++; if (bus.hi_out !== 32'd2) begin n_fail++; $display("FAIL divu_hi got=%h exp=00000002", bus.hi_out); end
        release_op();
    endtask

    task automatic test_div_signed;
        int dc, sb;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, dc, sb);
        n_run++; if (dc !== 33) begin n_fail++; $display("FAIL divs_latency got=%0d exp=33", dc); end
        n_run++; if (bus.lo_out !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL divs_lo got=%h exp=fffffffd", bus.lo_out); end
        n_run++; if (bus.hi_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divs_hi got=%h exp=ffffffff", bus.hi_out); end
        release_op();
    endtask

    task automatic test_div_zero;
        int dc, sb;
        run_op(2'b10, 32'h1234_5678, 32'd0, dc, sb);
        n_run++; if (dc !== DZ_CYC) begin n_fail++; $display("FAIL divz_latency got=%0d exp=%0d", dc, DZ_CYC); end
        n_run++; if (bus.lo_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divz_lo got=%h exp=ffffffff", bus.lo_out); end
        n_run++; if (bus.hi_out !== 32'h1234_5678) begin n_fail++; $display("FAIL divz_hi got=%h exp=12345678", bus.hi_out); end
        release_op();
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, dc, sb);
        n_run++; if (dc !== DZ_CYC) begin n_fail++; $display("FAIL divzn_latency got=%0d exp=%0d", dc, DZ_CYC); end
        n_run++; if (bus.lo_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divzn_lo got=%h exp=ffffffff", bus.lo_out); end
        n_run++; if (bus.hi_out !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL divzn_hi got=%h exp=fffffff9", bus.hi_out); end
        release_op();
    endtask

    task automatic test_flush;
        int sb;
        int db;
        sb = 0; db = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'd100; bus.src_b = 32'd7;
        #1;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk); #1;
            if (bus.stall !== 1'b1) sb++;
        end
        n_run++; if (sb !== 0) begin n_fail++; $display("FAIL flush_pre_stall got=%0d low cycles exp=0", sb); end
        @(negedge clk); bus.flush = 1'b1; #1;
        n_run++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_stall got=%b exp=0", bus.stall); end
        n_run++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_done got=%b exp=0", bus.done); end
        @(negedge clk); bus.flush = 1'b0; bus.start = 1'b0; #1;
        n_run++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall got=%b exp=0", bus.stall); end
        for (int c = 12; c < 45; c++) begin
            @(negedge clk); #1;
            if (bus.done !== 1'b0) db++;
        end
        n_run++; if (db !== 0) begin n_fail++; $display("FAIL flush_no_done got=%0d done cycles exp=0", db); end
        n_run++; if (bus.hi_out !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL flush_hi got=%h exp=fffffff9", bus.hi_out); end
        n_run++; if (bus.lo_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL flush_lo got=%h exp=ffffffff", bus.lo_out); end
    endtask

    task automatic test_hold_no_restart;
        int dc, sb, hb;
        hb = 0;
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, dc, sb);
        n_run++; if (dc !== MC + 1) begin n_fail++; $display("FAIL hold_latency got=%0d exp=%0d", dc, MC + 1); end
        n_run++; if (bus.hi_out !== 32'd1) begin n_fail++; $display("FAIL hold_hi got=%h exp=00000001", bus.hi_out); end
        n_run++; if (bus.lo_out !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL hold_lo got=%h exp=fffffffe", bus.lo_out); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            if (bus.done !== 1'b1 || bus.stall !== 1'b1) hb++;
            if (bus.hi_out !== 32'd1 || bus.lo_out !== 32'hFFFF_FFFE) hb++;
        end
        n_run++; if (hb !== 0) begin n_fail++; $display("FAIL hold_stable got=%0d bad samples exp=0", hb); end
        release_op();
        n_run++; if ({bus.done, bus.stall} !== 2'b00) begin n_fail++; $display("FAIL hold_release got=%b exp=00", {bus.done, bus.stall}); end
    endtask

    task automatic test_back_to_back;
        int dc, sb;
        run_op(2'b01, 32'd3, 32'd4, dc, sb);
        n_run++; if (bus.lo_out !== 32'd12) begin n_fail++; $display("FAIL b2b_first_lo got=%h exp=0000000c", bus.lo_out); end
        @(negedge clk);
        bus.advance = 1'b1; bus.op = 2'b00; bus.src_a = 32'd7; bus.src_b = 32'hFFFF_FFFE;
        #1;
        n_run++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_adv_done got=%b exp=1", bus.done); end
        @(negedge clk); bus.advance = 1'b0; #1;
        n_run++; if ({bus.done, bus.stall} !== 2'b01) begin n_fail++; $display("FAIL b2b_idle got=%b exp=01", {bus.done, bus.stall}); end
        dc = -1;
        for (int c = 1; c < 20; c++) begin
            @(negedge clk); #1;
            if (bus.done === 1'b1) begin
                dc = c;
                break;
            end
        end
        n_run++; if (dc !== MC + 1) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", dc, MC + 1); end
        n_run++; if (bus.hi_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_hi got=%h exp=ffffffff", bus.hi_out); end
        n_run++; if (bus.lo_out !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL b2b_lo got=%h exp=fffffff2", bus.lo_out); end
        @(negedge clk); bus.flush = 1'b1; bus.advance = 1'b1; bus.start = 1'b0; #1;
        n_run++; if ({bus.done, bus.stall} !== 2'b00) begin n_fail++; $display("FAIL b2b_flush_adv got=%b exp=00", {bus.done, bus.stall}); end
        @(negedge clk); bus.flush = 1'b0; bus.advance = 1'b0; #1;
        n_run++; if ({bus.done, bus.stall} !== 2'b00) begin n_fail++; $display("FAIL b2b_after_flush got=%b exp=00", {bus.done, bus.stall}); end
        n_run++; if (bus.lo_out !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL b2b_flush_lo got=%h exp=fffffff2", bus.lo_out); end
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        test_reset();
        test_mult_signed();
        test_divu();
        test_div_signed();
        test_div_zero();
        test_flush();
        test_hold_no_restart();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the shared multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU operations and runs the multi-cycle arithmetic. It drives the `stall`/`done` pair consumed by the hazard unit and holds the HI/LO result until the pipeline advances past EX. It also aborts cleanly on an exception flush.

## Interface
Parameters:
- MUL_CYCLES, 4: cycles the registered multiplier result is held busy before completion (1..15).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  EX holds a valid mul/div op (level; may stay high across cycles)
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  32  rs operand (multiplicand / dividend)
- src_b  in  32  rt operand (multiplier / divisor)
- flush  in  1  exception clean; aborts any operation
- advance  in  1  EX→MEM transfer this cycle (pipeline not stalled at E)
- stall  out  1  request to freeze F/D/E/M/W
- done  out  1  result valid on hi_out/lo_out
- hi_out  out  32  HI result (product high / remainder)
- lo_out  out  32  LO result (product low / quotient)

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - start & !flush → latch op, operand signs, |src_a|, |src_b| (absolute values only for signed ops); go to MUL if op[1]=0, else DIV.
  - stall = start & !flush, combinational.
- MUL:
  - full 64-bit product of the latched magnitudes is registered on entry.
  - 4-bit counter runs MUL_CYCLES-1 down to 0; at 0 → DONE.
  - signed ops negate the product (two's complement, 64-bit) if the signs differ.
- DIV:
  - radix-2 restoring, one quotient bit per cycle, 32 iterations (5-bit counter), then → DONE.
  - signed fixup: quotient negated if the signs differ; remainder takes the dividend's sign.
- Divisor zero (any op): lo=0xFFFFFFFF, hi=src_a, fixup bypassed. Architecturally fixed value.
- DONE:
  - done=1, stall=1, hi_out/lo_out stable.
  - advance → IDLE. Otherwise stay, which covers other stall sources holding EX.
  - start is ignored in DONE, so the same instruction never restarts.
- flush in any state → IDLE next cycle; stall=0 and done=0 in the flush cycle; hi_out/lo_out unchanged.
- stall=1 in MUL, DIV and DONE unless flush.
- Reset: state IDLE, stall=0, done=0, hi_out=0, lo_out=0, counters 0.

## Timing
- Cycle 0 = first cycle start is high in IDLE.
- MUL: done first asserted in cycle MUL_CYCLES+1.
- DIV: iterations in cycles 1..32; done in cycle 33.
- Results are registered and valid in every done cycle.
- Back-to-back ops: after DONE→IDLE the next start is accepted no earlier than the following cycle (one IDLE cycle minimum).
- flush and advance simultaneous in DONE: flush wins, result discarded.
- rst dominates flush and start.

## Configuration
- DIV_ZERO_FAST_EN defined: zero divisor is detected in IDLE and the FSM goes directly to DONE. done appears in cycle 1 with lo=0xFFFFFFFF, hi=src_a.
- Not defined: zero divisor runs the full 32 iterations (done in cycle 33). Results are identical to the defined case; only latency differs.

## Structure
- Shared package: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), FSM state typedef, DIV_ITERS=32.
- One sub-module, `div_radix2_step`: combinational single restoring iteration taking {partial remainder, dividend shift register, divisor} and producing the next remainder and quotient bit. muldiv_ctrl owns all registers and the FSM.

## Test plan
- MULT src_a=0xFFFFFFFD (-3), src_b=5 → done at cycle MUL_CYCLES+1, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU 100/7 → done at cycle 33, lo=14, hi=2; stall high cycles 0..33.
- DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x12345678 / 0 → lo=0xFFFFFFFF, hi=0x12345678. Done at cycle 1 with DIV_ZERO_FAST_EN, at cycle 33 without.
- DIVU started, flush pulsed in cycle 10 → stall=0 in cycle 10, state IDLE in cycle 11, done never asserted, hi/lo unchanged.
- MULTU 0xFFFFFFFF*2 reaches DONE; advance held 0 for 3 cycles with start high → done/stall stay high, no restart. Result hi=1, lo=0xFFFFFFFE. advance=1 → IDLE next cycle.
